operand_stream_driver: RTL and testbench
========================================

// Module: operand_stream_driver
// PURPOSE
//  Parametrised operand streamer for the bfm-style DUT harness. It buffers {A,B} operand pairs
//  loaded from the stimulus side and issues exactly len_i of them over a valid/ready bus. It
//  counts returned results and raises done_o after a fixed drain window.
//  Synthesisable; DPI/stimulus code sits outside it.
// PARAMETERS
//  DATA_W        8     width of each operand A and B
//  RES_W         8     width of result bus from DUT
//  DEPTH         16    operand FIFO entries; power of 2, >=2
//  CNT_W         32    width of length/transaction counters
//  DRAIN_CYCLES  2     cycles spent in DRAIN after last issue before DONE; >=1
// PORTS
//  clk_i        in   1          clock, rising edge
//  reset_i      in   1          asynchronous, active-high reset
//  start_i      in   1          pulse: begin a run of len_i transactions
//  len_i        in   CNT_W      transaction count, sampled when start_i is accepted
//  ld_valid_i   in   1          load side: operand pair valid
//  ld_data_i    in   2*DATA_W   {A,B}; A in upper half
//  ld_ready_o   out  1          load side: FIFO not full
//  op_valid_o   out  1          operand pair presented to DUT
//  op_a_o       out  DATA_W     operand A
//  op_b_o       out  DATA_W     operand B
//  op_ready_i   in   1          DUT accepts operand pair
//  res_valid_i  in   1          DUT result valid (no backpressure)
//  res_i        in   RES_W      DUT result
//  busy_o       out  1          state is RUN or DRAIN
//  done_o       out  1          state is DONE
//  sent_cnt_o   out  CNT_W      handshakes issued this run
//  res_cnt_o    out  CNT_W      results received this run
//  checksum_o   out  RES_W      present only with RES_CHECKSUM_EN
// BEHAVIOUR
//  Reset (async): FIFO empty; state IDLE; all counters 0; op_valid_o=0; busy_o=0; done_o=0;
//   checksum 0. ld_ready_o=1 once reset deasserts. A mid-run reset discards FIFO contents and the run.
//  FIFO: push on ld_valid_i&&ld_ready_o; ld_ready_o = !full. No push when full, even with a
//   same-cycle pop. Show-ahead head drives op_a_o/op_b_o.
//   An entry pushed into an empty FIFO is visible on the op bus the next cycle; no bypass.
//  Loading is allowed in every state, so the FIFO can be pre-filled in IDLE.
//  op_valid_o = (state==RUN) && !empty && (sent_cnt_o < len).
//   Pop/issue on op_valid_o&&op_ready_i; sent_cnt_o += 1.
//   Once op_valid_o is high, it and op_a_o/op_b_o stay stable until the handshake.
//   The rule holds because pops occur only on the handshake and len is frozen.
//  FSM:
//   IDLE : start_i -> latch len_i; clear counters and checksum.
//          Go to RUN, or to DRAIN if len_i==0.
//   RUN  : handshake making sent_cnt_o==len -> DRAIN, in the same edge as the last pop.
//          Load drop-outs (empty) simply stall.
//   DRAIN: down-counter from DRAIN_CYCLES. After DRAIN_CYCLES cycles -> DONE.
//   DONE : hold until start_i, then act as in IDLE. Counters stay readable until that start.
//   start_i is ignored in RUN and DRAIN.
//  Results: in RUN/DRAIN, res_valid_i increments res_cnt_o, saturating at all-ones.
//   Results are ignored in IDLE/DONE. Results may arrive in the same cycle as the last issue.
//  Leftover FIFO entries beyond len are retained for the next run.
// CONFIGURATION
//  RES_CHECKSUM_EN defined: checksum_o port exists. On each counted result,
//   checksum <= {checksum[RES_W-2:0],checksum[RES_W-1]} ^ res_i. Cleared on start.
//  RES_CHECKSUM_EN undefined: no checksum_o port and no checksum register; all else identical.
// STRUCTURE
//  Package operand_stream_pkg: typedef enum logic[1:0] {IDLE,RUN,DRAIN,DONE} drv_state_e;
//   localparam DRAIN_CYCLES_DEFAULT=2.
//  Sub-module op_fifo: sync FIFO; params WIDTH, DEPTH.
//   Ports clk_i, reset_i, push, din, pop, dout, full, empty.
//   Pointers are log2(DEPTH)+1 bits, with full/empty taken from the MSB compare.
// TESTING
//  1 DEPTH=4. Load 6 pairs {1,2} while RUN; len=6; op_ready_i=1.
//    -> 6 handshakes with A=1, B=2; sent_cnt_o=6; done_o rises DRAIN_CYCLES=2 cycles after the last.
//  2 Backpressure: op_ready_i=0 for 3 cycles with op_valid_o=1 and head {5,9}.
//    -> op_a_o=5 and op_b_o=9 held and valid for all 3 cycles; one handshake on release.
//  3 Full: IDLE, push 5 pairs into DEPTH=4. -> ld_ready_o=0 after the 4th push.
//    The 5th is not accepted until the first pop in RUN.
//  4 len=0 start -> no op_valid_o ever; busy_o for 2 cycles; then done_o=1, sent_cnt_o=0.
//  5 reset_i pulsed mid-RUN (sent=3 of 8).
//    -> all outputs to reset values asynchronously; FIFO empty; a new start works.
//  6 RES_CHECKSUM_EN, RES_W=8: results 0x03,0x03. -> checksum_o=0x03, then 0x05; res_cnt_o=2.

Source files
------------

// File: rtl/operand_stream_pkg.sv
// ---------------------------------------------------------------------------
// operand_stream_pkg
// Shared types and defaults for the operand stream driver.
//   drv_state_e          : driver FSM state encoding
//   DRAIN_CYCLES_DEFAULT : default length of the post-issue drain window
// ---------------------------------------------------------------------------
package operand_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } drv_state_e;

  localparam int DRAIN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/op_fifo.sv
// ---------------------------------------------------------------------------
// op_fifo
// Synchronous show-ahead FIFO holding {A,B} operand pairs.
// Ports:
//   clk_i   in  clock, rising edge
//   reset_i in  asynchronous active-high reset (empties the FIFO)
//   push    in  write din (ignored when full, even if a pop happens too)
//   din     in  WIDTH-bit entry to write
//   pop     in  drop the head entry (ignored when empty)
//   dout    out head entry, valid whenever empty is low
//   full    out no free entries
//   empty   out no stored entries
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs when the index bits match.
// ---------------------------------------------------------------------------
module op_fifo
  import operand_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; reset drops any stored entries by re-aligning pointers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/operand_stream_driver.sv
// ---------------------------------------------------------------------------
// operand_stream_driver
// Buffers {A,B} operand pairs from the stimulus side and issues exactly len_i
// of them over a valid/ready bus, counts returned results and raises done_o
// after a fixed drain window.
// Ports:
//   clk_i, reset_i            clock / asynchronous active-high reset
//   start_i, len_i            start pulse and transaction count (IDLE/DONE only)
//   ld_valid_i, ld_data_i     load side {A,B}, A in the upper half
//   ld_ready_o                load side ready (FIFO not full)
//   op_valid_o, op_a_o, op_b_o, op_ready_i   operand bus towards the DUT
//   res_valid_i, res_i        DUT results (no backpressure)
//   busy_o, done_o            RUN/DRAIN and DONE indicators
//   sent_cnt_o, res_cnt_o     issued handshakes / received results this run
//   checksum_o                rotate-xor checksum of results
// Optional feature macro: RES_CHECKSUM_EN adds checksum_o and its register.
// ---------------------------------------------------------------------------
module operand_stream_driver
  import operand_stream_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int RES_W        = 8,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic                ld_valid_i,
  input  logic [2*DATA_W-1:0] ld_data_i,
  output logic                ld_ready_o,
  output logic                op_valid_o,
  output logic [DATA_W-1:0]   op_a_o,
  output logic [DATA_W-1:0]   op_b_o,
  input  logic                op_ready_i,
  input  logic                res_valid_i,
  input  logic [RES_W-1:0]    res_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    sent_cnt_o,
  output logic [CNT_W-1:0]    res_cnt_o
`ifdef RES_CHECKSUM_EN
  ,
  output logic [RES_W-1:0]    checksum_o
`endif
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  drv_state_e          state;
  drv_state_e          next_state;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    sent_cnt;
  logic [CNT_W-1:0]    res_cnt;
  logic [DRN_W-1:0]    drain_cnt;
  logic [2*DATA_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept_start;
  logic                issue;
  logic                last_issue;
  logic                res_count;

  op_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (ld_valid_i && ld_ready_o),
    .din     (ld_data_i),
    .pop     (issue),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ld_ready_o   = !fifo_full;
  assign op_a_o       = fifo_dout[2*DATA_W-1:DATA_W];
  assign op_b_o       = fifo_dout[DATA_W-1:0];
  assign accept_start = start_i && ((state == IDLE) || (state == DONE));
  assign issue        = op_valid_o && op_ready_i;
  // len_q is at least 1 whenever RUN is active, so the subtraction cannot wrap.
  assign last_issue   = issue && (sent_cnt == len_q - CNT_W'(1));
  assign res_count    = res_valid_i && ((state == RUN) || (state == DRAIN));
  assign sent_cnt_o   = sent_cnt;
  assign res_cnt_o    = res_cnt;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a zero-length run skips RUN and goes straight to the drain window.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_i) next_state = (len_i == '0) ? DRAIN : RUN;
      RUN:        if (last_issue) next_state = DRAIN;
      DRAIN:      if (drain_cnt == DRN_W'(1)) next_state = DONE;
    endcase
  end

  // Output decode; op_valid_o depends only on registered state so it stays
  // stable until the handshake pops the head.
  always_comb begin
    op_valid_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    if (state == RUN && !fifo_empty && (sent_cnt < len_q)) op_valid_o = 1'b1;
    if (state == RUN || state == DRAIN) busy_o = 1'b1;
    if (state == DONE) done_o = 1'b1;
  end

  // Run counters and drain timer; counters stay readable in DONE until the next start.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      len_q     <= '0;
      sent_cnt  <= '0;
      res_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept_start) begin
        len_q    <= len_i;
        sent_cnt <= '0;
        res_cnt  <= '0;
      end else begin
        if (issue) sent_cnt <= sent_cnt + CNT_W'(1);
        if (res_count && (res_cnt != '1)) res_cnt <= res_cnt + CNT_W'(1);
      end
      if (next_state == DRAIN && state != DRAIN) drain_cnt <= DRN_W'(DRAIN_CYCLES);
      else if (state == DRAIN)                   drain_cnt <= drain_cnt - DRN_W'(1);
    end
  end

`ifdef RES_CHECKSUM_EN
  logic [RES_W-1:0] checksum_q;

  // Rotate-left-then-xor checksum over every result counted during RUN/DRAIN.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)           checksum_q <= '0;
    else if (accept_start) checksum_q <= '0;
    else if (res_count)    checksum_q <= {checksum_q[RES_W-2:0], checksum_q[RES_W-1]} ^ res_i;
  end

  assign checksum_o = checksum_q;
`else
  logic unused_res;
  assign unused_res = ^res_i;
`endif

endmodule

// File: tb/tb_operand_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_operand_stream_driver
// Directed bench for operand_stream_driver (DEPTH=4, CNT_W=8, DRAIN_CYCLES=2).
// Loaded pairs are queued as expected operands; a negedge monitor pops and
// compares on every operand handshake. Status outputs are checked directly.
// Optional feature macro: RES_CHECKSUM_EN enables the checksum checks.
// ---------------------------------------------------------------------------
module tb_operand_stream_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  lenIn;
  logic        ldValid;
  logic [15:0] ldData;
  logic        ldReady;
  logic        opValid;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic        opReady;
  logic        resValid;
  logic [7:0]  resIn;
  logic        busy;
  logic        done;
  logic [7:0]  sentCnt;
  logic [7:0]  resCnt;
`ifdef RES_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int          checkCount = 0;
  int          passCount  = 0;
  int          hsCount    = 0;
  int          hsStart    = 0;
  int          cycleNo    = 0;
  int          lastHsEdge = 0;
  logic [15:0] expQ[$];
  logic [15:0] expPair;
  logic [7:0]  expRes;
  logic [7:0]  expSum;

  always #5 clk = ~clk;

  operand_stream_driver #(
    .DATA_W       (8),
    .RES_W        (8),
    .DEPTH        (4),
    .CNT_W        (8),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .len_i       (lenIn),
    .ld_valid_i  (ldValid),
    .ld_data_i   (ldData),
    .ld_ready_o  (ldReady),
    .op_valid_o  (opValid),
    .op_a_o      (opA),
    .op_b_o      (opB),
    .op_ready_i  (opReady),
    .res_valid_i (resValid),
    .res_i       (resIn),
    .busy_o      (busy),
    .done_o      (done),
    .sent_cnt_o  (sentCnt),
    .res_cnt_o   (resCnt)
`ifdef RES_CHECKSUM_EN
    ,
    .checksum_o  (checksum)
`endif
  );

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard monitor: each handshake must present the oldest loaded pair.
  always @(negedge clk) begin
    if (!reset && opValid && opReady) begin
      hsCount++;
      lastHsEdge = cycleNo + 1;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL sb_unexpected: got 0x%04h, expected no handshake", {opA, opB});
      end else begin
        expPair = expQ.pop_front();
        checkOutput("sb_operands", {16'h0, opA, opB}, {16'h0, expPair});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one pair, waiting for ld_ready, and queues it as an expected operand.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    logic got;
    got     = 1'b0;
    ldValid = 1'b1;
    ldData  = {a, b};
    for (int i = 0; i < 50 && !got; i++) begin
      if (ldReady) begin
        got = 1'b1;
        expQ.push_back({a, b});
      end
      tick();
    end
    ldValid = 1'b0;
    checkOutput("load_accepted", {31'h0, got}, 32'h1);
  endtask

  task automatic startRun(input logic [7:0] len);
    start = 1'b1;
    lenIn = len;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    checkOutput("done_reached", {31'h0, done}, 32'h1);
  endtask

  task automatic driveResult(input logic [7:0] value);
    resValid = 1'b1;
    resIn    = value;
    expRes   = (expRes == 8'hFF) ? 8'hFF : expRes + 8'h1;
    expSum   = {expSum[6:0], expSum[7]} ^ value;
    tick();
    resValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; lenIn = '0; ldValid = 1'b0; ldData = '0;
    opReady = 1'b0; resValid = 1'b0; resIn = '0; expRes = '0; expSum = '0;
    tick(); tick();
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_op_valid", {31'h0, opValid}, 32'h0);
    checkOutput("rst_sent", {24'h0, sentCnt}, 32'h0);
    checkOutput("rst_res", {24'h0, resCnt}, 32'h0);
`ifdef RES_CHECKSUM_EN
    checkOutput("rst_checksum", {24'h0, checksum}, 32'h0);
`endif
    reset = 1'b0;
    tick();
    checkOutput("rst_ld_ready", {31'h0, ldReady}, 32'h1);

    $display("[TB] full FIFO in IDLE");
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 8'h20 + 8'(i));
    checkOutput("full_ld_ready", {31'h0, ldReady}, 32'h0);
    ldValid = 1'b1;
    ldData  = 16'h1424;
    tick(); tick();
    checkOutput("full_hold", {31'h0, ldReady}, 32'h0);
    opReady = 1'b1;
    startRun(8'd1);
    checkOutput("full_after_start", {31'h0, ldReady}, 32'h0);
    checkOutput("full_op_valid", {31'h0, opValid}, 32'h1);
    checkOutput("full_head_a", {24'h0, opA}, 32'h10);
    tick();
    checkOutput("ready_after_pop", {31'h0, ldReady}, 32'h1);
    expQ.push_back(16'h1424);
    tick();
    ldValid = 1'b0;
    checkOutput("refull", {31'h0, ldReady}, 32'h0);
    waitDone(20);
    checkOutput("full_sent", {24'h0, sentCnt}, 32'h1);

    $display("[TB] leftovers retained");
    hsStart = hsCount;
    startRun(8'd4);
    waitDone(30);
    checkOutput("left_hs", hsCount - hsStart, 32'd4);
    checkOutput("left_sent", {24'h0, sentCnt}, 32'h4);
    checkOutput("left_queue", expQ.size(), 32'd0);
    checkOutput("left_ld_ready", {31'h0, ldReady}, 32'h1);

    $display("[TB] backpressure");
    opReady = 1'b0;
    applyStimulus(8'h05, 8'h09);
    applyStimulus(8'h07, 8'h03);
    startRun(8'd2);
    hsStart = hsCount;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_valid", {31'h0, opValid}, 32'h1);
      checkOutput("bp_a", {24'h0, opA}, 32'h05);
      checkOutput("bp_b", {24'h0, opB}, 32'h09);
      tick();
    end
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    checkOutput("bp_one_hs", hsCount - hsStart, 32'd1);
    checkOutput("bp_sent", {24'h0, sentCnt}, 32'h1);
    checkOutput("bp_next_a", {24'h0, opA}, 32'h07);
    opReady = 1'b1;
    waitDone(20);
    checkOutput("bp_sent_final", {24'h0, sentCnt}, 32'h2);

    $display("[TB] six pairs loaded during RUN");
    hsStart = hsCount;
    startRun(8'd6);
    for (int i = 0; i < 6; i++) applyStimulus(8'h01, 8'h02);
    waitDone(20);
    checkOutput("run6_hs", hsCount - hsStart, 32'd6);
    checkOutput("run6_sent", {24'h0, sentCnt}, 32'h6);
    checkOutput("run6_drain_latency", cycleNo - lastHsEdge, 32'd2);

    $display("[TB] zero-length run");
    applyStimulus(8'hAA, 8'hBB);
    hsStart = hsCount;
    expRes  = '0;
    expSum  = '0;
    startRun(8'd0);
    checkOutput("len0_busy1", {31'h0, busy}, 32'h1);
    checkOutput("len0_done1", {31'h0, done}, 32'h0);
    checkOutput("len0_valid1", {31'h0, opValid}, 32'h0);
    driveResult(8'h03);
    checkOutput("len0_busy2", {31'h0, busy}, 32'h1);
    checkOutput("len0_done2", {31'h0, done}, 32'h0);
    checkOutput("len0_valid2", {31'h0, opValid}, 32'h0);
    checkOutput("len0_res_in_drain", {24'h0, resCnt}, 32'h1);
    tick();
    checkOutput("len0_busy3", {31'h0, busy}, 32'h0);
    checkOutput("len0_done3", {31'h0, done}, 32'h1);
    checkOutput("len0_sent", {24'h0, sentCnt}, 32'h0);
    resValid = 1'b1;
    tick();
    resValid = 1'b0;
    checkOutput("res_ignored_done", {24'h0, resCnt}, 32'h1);
    checkOutput("len0_no_hs", hsCount - hsStart, 32'd0);

    $display("[TB] results and saturation");
    expRes = '0;
    expSum = '0;
    startRun(8'd2);
    driveResult(8'h03);
    checkOutput("res_cnt_1", {24'h0, resCnt}, 32'h1);
`ifdef RES_CHECKSUM_EN
    checkOutput("checksum_1", {24'h0, checksum}, 32'h03);
`endif
    driveResult(8'h03);
    checkOutput("res_cnt_2", {24'h0, resCnt}, 32'h2);
`ifdef RES_CHECKSUM_EN
    checkOutput("checksum_2", {24'h0, checksum}, 32'h05);
`endif
    checkOutput("res_stall_sent", {24'h0, sentCnt}, 32'h1);
    checkOutput("res_stall_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 253; i++) driveResult(i[7:0]);
    checkOutput("res_cnt_max", {24'h0, resCnt}, 32'hFF);
    for (int i = 0; i < 5; i++) driveResult(8'h5A + 8'(i));
    checkOutput("res_saturate", {24'h0, resCnt}, {24'h0, expRes});
`ifdef RES_CHECKSUM_EN
    checkOutput("checksum_long", {24'h0, checksum}, {24'h0, expSum});
`endif
    applyStimulus(8'h33, 8'h44);
    waitDone(20);
    checkOutput("res_run_sent", {24'h0, sentCnt}, 32'h2);

    $display("[TB] reset mid-run");
    opReady = 1'b1;
    hsStart = hsCount;
    startRun(8'd8);
    for (int i = 0; i < 3; i++) applyStimulus(8'h60 + 8'(i), 8'h70 + 8'(i));
    tick();
    opReady = 1'b0;
    checkOutput("mid_hs", hsCount - hsStart, 32'd3);
    checkOutput("mid_sent", {24'h0, sentCnt}, 32'h3);
    applyStimulus(8'h63, 8'h73);
    applyStimulus(8'h64, 8'h74);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'h0, opValid}, 32'h0);
    checkOutput("async_busy", {31'h0, busy}, 32'h0);
    checkOutput("async_done", {31'h0, done}, 32'h0);
    checkOutput("async_sent", {24'h0, sentCnt}, 32'h0);
    checkOutput("async_ld_ready", {31'h0, ldReady}, 32'h1);
    expQ.delete();
    tick();
    reset = 1'b0;
    tick();
    opReady = 1'b1;
    startRun(8'd1);
    checkOutput("post_rst_empty", {31'h0, opValid}, 32'h0);
    checkOutput("post_rst_busy", {31'h0, busy}, 32'h1);
    applyStimulus(8'h5A, 8'hA5);
    waitDone(20);
    checkOutput("post_rst_sent", {24'h0, sentCnt}, 32'h1);
    checkOutput("final_queue", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
